// File: rtl/axi4_ram_read_arbiter_if.sv
// Bus bundle between NUM_MASTERS AXI4 read masters, the read arbiter and the
// 128-bit on-chip RAM read port (AR/R channels only).
interface axi4_ram_read_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 128
);
    logic [NUM_MASTERS-1:0]            m_ar_valid;
    logic [NUM_MASTERS-1:0]            m_ar_ready;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_ar_addr;
    logic [NUM_MASTERS*8-1:0]          m_ar_len;
    logic [NUM_MASTERS*3-1:0]          m_ar_size;
    logic [NUM_MASTERS*2-1:0]          m_ar_burst;
    logic [NUM_MASTERS-1:0]            m_r_valid;
    logic [NUM_MASTERS-1:0]            m_r_ready;
    logic [DATA_WIDTH-1:0]             m_r_data;
    logic [1:0]                        m_r_resp;
    logic                              m_r_last;

    logic                              ram_ar_valid;
    logic                              ram_ar_ready;
    logic [ADDR_WIDTH-1:0]             ram_ar_addr;
    logic [7:0]                        ram_ar_len;
    logic [2:0]                        ram_ar_size;
    logic [1:0]                        ram_ar_burst;
    logic                              ram_r_valid;
    logic                              ram_r_ready;
    logic [DATA_WIDTH-1:0]             ram_r_data;
    logic [1:0]                        ram_r_resp;
    logic                              ram_r_last;

    // Arbiter view: slave towards the masters, master towards the RAM.
    modport slave (
        input  m_ar_valid, m_ar_addr, m_ar_len, m_ar_size, m_ar_burst, m_r_ready,
               ram_ar_ready, ram_r_valid, ram_r_data, ram_r_resp, ram_r_last,
        output m_ar_ready, m_r_valid, m_r_data, m_r_resp, m_r_last,
               ram_ar_valid, ram_ar_addr, ram_ar_len, ram_ar_size, ram_ar_burst, ram_r_ready
    );

    // Environment view: the requesting masters plus the RAM.
    modport master (
        output m_ar_valid, m_ar_addr, m_ar_len, m_ar_size, m_ar_burst, m_r_ready,
               ram_ar_ready, ram_r_valid, ram_r_data, ram_r_resp, ram_r_last,
        input  m_ar_ready, m_r_valid, m_r_data, m_r_resp, m_r_last,
               ram_ar_valid, ram_ar_addr, ram_ar_len, ram_ar_size, ram_ar_burst, ram_r_ready
    );
endinterface

// File: rtl/axi4_ram_read_arbiter.sv
// Round-robin, whole-burst read arbiter for the on-chip RAM: one burst in
// flight, R beats steered back to the granted master, sticky ARLEN/beat check.
module axi4_ram_read_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 128,
    localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    axi4_ram_read_arbiter_if.slave   bus_if,
    output logic [GW-1:0]            grant_id,
    output logic                     busy,
    output logic                     len_error
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic [7:0]      exp_len_q, exp_len_d;
    logic [7:0]      beat_cnt_q, beat_cnt_d;
    logic            len_error_q, len_error_d;

    logic [GW-1:0]          winner_s;
    logic                   found_s;
    logic [NUM_MASTERS-1:0] m_ar_ready_s;
    logic [NUM_MASTERS-1:0] m_r_valid_s;
    logic                   ram_r_ready_s;
    logic                   ar_hs_s;
    logic                   r_hs_s;

    // Round-robin search starting just after the last completed master.
    always_comb begin
        winner_s = '0;
        found_s  = 1'b0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            if (!found_s && bus_if.m_ar_valid[(int'(last_grant_q) + k) % NUM_MASTERS]) begin
                found_s  = 1'b1;
                winner_s = GW'((int'(last_grant_q) + k) % NUM_MASTERS);
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Granted master's AR fields go straight to the RAM; AXI keeps them stable.
    assign bus_if.ram_ar_addr  = bus_if.m_ar_addr[int'(grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
    assign bus_if.ram_ar_len   = bus_if.m_ar_len[int'(grant_q)*8 +: 8];
    assign bus_if.ram_ar_size  = bus_if.m_ar_size[int'(grant_q)*3 +: 3];
    assign bus_if.ram_ar_burst = bus_if.m_ar_burst[int'(grant_q)*2 +: 2];
    assign bus_if.ram_ar_valid = (state_q == ST_ADDR);

    assign bus_if.m_r_data = bus_if.ram_r_data;
    assign bus_if.m_r_resp = bus_if.ram_r_resp;
    assign bus_if.m_r_last = bus_if.ram_r_last;

    // Per-master handshake steering towards the granted master only.
    always_comb begin
        m_ar_ready_s  = '0;
        m_r_valid_s   = '0;
        ram_r_ready_s = (state_q == ST_DATA) && bus_if.m_r_ready[grant_q];
        for (int i = 0; i < NUM_MASTERS; i++) begin
            m_ar_ready_s[i] = (state_q == ST_ADDR) && (grant_q == GW'(i)) && bus_if.ram_ar_ready;
            m_r_valid_s[i]  = (state_q == ST_DATA) && (grant_q == GW'(i)) && bus_if.ram_r_valid;
        end
    end

    assign bus_if.m_ar_ready  = m_ar_ready_s;
    assign bus_if.m_r_valid   = m_r_valid_s;
    assign bus_if.ram_r_ready = ram_r_ready_s;

    assign ar_hs_s = (state_q == ST_ADDR) && bus_if.ram_ar_ready;
    assign r_hs_s  = (state_q == ST_DATA) && bus_if.ram_r_valid && ram_r_ready_s;

    // Next-state logic for the grant FSM and the beat/length checker.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        exp_len_d    = exp_len_q;
        beat_cnt_d   = beat_cnt_q;
        len_error_d  = len_error_q;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    grant_d = winner_s;
                    state_d = ST_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (ar_hs_s) begin
                    exp_len_d  = bus_if.ram_ar_len;
                    beat_cnt_d = 8'd0;
                    state_d    = ST_DATA;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (r_hs_s) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (bus_if.ram_r_last) begin
                        // Short (or exactly-long-but-wrong) burst ends here.
                        if (beat_cnt_q != exp_len_q) begin
                            len_error_d = 1'b1;
                        end else begin
                            len_error_d = len_error_q;
                        end
                        last_grant_d = grant_q;
                        state_d      = ST_IDLE;
                    end else if (beat_cnt_q == exp_len_q) begin
                        len_error_d = 1'b1;
                    end else begin
                        len_error_d = len_error_q;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_MASTERS - 1);
            exp_len_q    <= 8'd0;
            beat_cnt_q   <= 8'd0;
            len_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            exp_len_q    <= exp_len_d;
            beat_cnt_q   <= beat_cnt_d;
            len_error_q  <= len_error_d;
        end
    end

    assign grant_id  = grant_q;
    assign busy      = (state_q != ST_IDLE);
    assign len_error = len_error_q;

endmodule

// File: tb/tb_axi4_ram_read_arbiter.sv
// Directed bench for axi4_ram_read_arbiter with two masters; the bench plays
// both masters and the RAM and checks every step against hand-derived values.
module tb_axi4_ram_read_arbiter;

    localparam int NM = 2;

    logic clk;
    logic reset;
    logic grant_id;
    logic busy;
    logic len_error;
    int   tests;
    int   fails;

    axi4_ram_read_arbiter_if #(.NUM_MASTERS(NM), .ADDR_WIDTH(32), .DATA_WIDTH(128)) bus ();

    axi4_ram_read_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(32), .DATA_WIDTH(128)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus_if    (bus),
        .grant_id  (grant_id),
        .busy      (busy),
        .len_error (len_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] ram_word(input logic [31:0] a, input int b);
        logic [31:0] w;
        w = a + 32'(b * 16);
        return {w, ~w, w ^ 32'hA5A5_A5A5, w + 32'd1};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic request(input int m, input logic [31:0] addr, input logic [7:0] len);
        bus.m_ar_valid[m]          = 1'b1;
        bus.m_ar_addr[m*32 +: 32]  = addr;
        bus.m_ar_len[m*8 +: 8]     = len;
    endtask

    // Entered at a negedge with the DUT in ADDR for master m; returns at the
    // negedge of the IDLE cycle that follows the last beat.
    task automatic do_burst(input int m, input logic [31:0] addr, input logic [7:0] len,
                            input int nbeats, input bit toggle, input bit keep);
        logic [NM-1:0] onehot;
        logic [3:0]    pat;
        logic          rdy;
        int            pi;
        int            b;
        onehot = NM'(1 << m);
        pat    = 4'b1001;
        #1;
        chk("ar_valid", 128'(bus.ram_ar_valid), 128'(1'b1));
        chk("ar_addr", 128'(bus.ram_ar_addr), 128'(addr));
        chk("ar_len", 128'(bus.ram_ar_len), 128'(len));
        chk("grant_id", 128'(grant_id), 128'(m));
        chk("busy_addr", 128'(busy), 128'(1'b1));
        bus.ram_ar_ready = 1'b1;
        #1;
        chk("m_ar_ready", 128'(bus.m_ar_ready), 128'(onehot));
        @(negedge clk);
        bus.ram_ar_ready = 1'b0;
        if (!keep) bus.m_ar_valid[m] = 1'b0;
        pi = 0;
        b  = 0;
        while (b < nbeats) begin
            rdy = toggle ? pat[pi % 4] : 1'b1;
            pi++;
            bus.ram_r_valid  = 1'b1;
            bus.ram_r_data   = ram_word(addr, b);
            bus.ram_r_last   = (b == nbeats - 1);
            bus.ram_r_resp   = 2'b00;
            bus.m_r_ready[m] = rdy;
            #1;
            chk("ram_r_ready", 128'(bus.ram_r_ready), 128'(rdy));
            chk("m_r_valid", 128'(bus.m_r_valid), 128'(onehot));
            chk("m_r_data", bus.m_r_data, ram_word(addr, b));
            chk("m_r_last", 128'(bus.m_r_last), 128'(b == nbeats - 1));
            chk("ar_valid_data", 128'(bus.ram_ar_valid), 128'(1'b0));
            @(negedge clk);
            if (rdy) b++;
        end
        bus.ram_r_valid = 1'b0;
        bus.ram_r_last  = 1'b0;
        bus.m_r_ready   = '0;
        #1;
        chk("busy_end", 128'(busy), 128'(1'b0));
        chk("ar_valid_idle", 128'(bus.ram_ar_valid), 128'(1'b0));
        chk("m_r_valid_idle", 128'(bus.m_r_valid), 128'(0));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        bus.m_ar_valid   = '0;
        bus.m_ar_addr    = '0;
        bus.m_ar_len     = '0;
        bus.m_ar_size    = {3'd4, 3'd4};
        bus.m_ar_burst   = {2'b01, 2'b01};
        bus.m_r_ready    = '0;
        bus.ram_ar_ready = 1'b0;
        bus.ram_r_valid  = 1'b0;
        bus.ram_r_data   = '0;
        bus.ram_r_resp   = 2'b00;
        bus.ram_r_last   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_grant", 128'(grant_id), 128'(1'b0));
        chk("rst_len_error", 128'(len_error), 128'(1'b0));
        chk("rst_ar_valid", 128'(bus.ram_ar_valid), 128'(1'b0));
        chk("rst_r_ready", 128'(bus.ram_r_ready), 128'(1'b0));
        chk("rst_m_ar_ready", 128'(bus.m_ar_ready), 128'(0));
        chk("rst_m_r_valid", 128'(bus.m_r_valid), 128'(0));
        reset = 1'b1;

        // Single master, len=3 INCR burst.
        @(negedge clk);
        request(0, 32'h100, 8'd3);
        #1;
        chk("t1_ar_valid_same_cycle", 128'(bus.ram_ar_valid), 128'(1'b0));
        @(negedge clk);
        do_burst(0, 32'h100, 8'd3, 4, 1'b0, 1'b0);
        chk("t1_len_error", 128'(len_error), 128'(1'b0));

        // Simultaneous requests right after reset: master 0 first.
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        request(0, 32'h200, 8'd1);
        request(1, 32'h300, 8'd1);
        @(negedge clk);
        do_burst(0, 32'h200, 8'd1, 2, 1'b0, 1'b0);
        chk("t2_addr_hold", 128'(bus.ram_ar_addr), 128'(32'h200));
        @(negedge clk);
        do_burst(1, 32'h300, 8'd1, 2, 1'b0, 1'b0);

        // Continuous requests from both: 0,1,0,1,0,1 with one IDLE bubble each.
        request(0, 32'h400, 8'd0);
        request(1, 32'h500, 8'd0);
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            do_burst(i % 2, (i % 2 == 1) ? 32'h500 : 32'h400, 8'd0, 1, 1'b0, 1'b1);
            if (i < 5) @(negedge clk);
        end
        bus.m_ar_valid = '0;

        // Master 1 len=7 with back-pressure pattern 1,0,0,1.
        request(1, 32'h600, 8'd7);
        @(negedge clk);
        do_burst(1, 32'h600, 8'd7, 8, 1'b1, 1'b0);
        chk("t4_len_error", 128'(len_error), 128'(1'b0));

        // Early last on beat 2 of len=3, then a normal burst.
        request(0, 32'h700, 8'd3);
        @(negedge clk);
        do_burst(0, 32'h700, 8'd3, 2, 1'b0, 1'b0);
        chk("t5_len_error_set", 128'(len_error), 128'(1'b1));
        request(1, 32'h800, 8'd1);
        @(negedge clk);
        do_burst(1, 32'h800, 8'd1, 2, 1'b0, 1'b0);
        chk("t5_len_error_sticky", 128'(len_error), 128'(1'b1));

        // Reset during beat 2 of a len=7 burst.
        request(1, 32'h900, 8'd7);
        @(negedge clk);
        bus.ram_ar_ready = 1'b1;
        @(negedge clk);
        bus.ram_ar_ready  = 1'b0;
        bus.m_ar_valid[1] = 1'b0;
        bus.ram_r_valid   = 1'b1;
        bus.ram_r_data    = ram_word(32'h900, 0);
        bus.m_r_ready[1]  = 1'b1;
        @(negedge clk);
        bus.ram_r_data = ram_word(32'h900, 1);
        #1;
        chk("t6_busy_before", 128'(busy), 128'(1'b1));
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("t6_busy", 128'(busy), 128'(1'b0));
        chk("t6_ar_valid", 128'(bus.ram_ar_valid), 128'(1'b0));
        chk("t6_r_ready", 128'(bus.ram_r_ready), 128'(1'b0));
        chk("t6_len_error", 128'(len_error), 128'(1'b0));
        bus.ram_r_valid = 1'b0;
        bus.m_r_ready   = '0;
        reset = 1'b1;
        request(0, 32'hA00, 8'd0);
        request(1, 32'hB00, 8'd0);
        @(negedge clk);
        do_burst(0, 32'hA00, 8'd0, 1, 1'b0, 1'b0);
        @(negedge clk);
        do_burst(1, 32'hB00, 8'd0, 1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
